// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: size codes, memory load/store
// opcodes, FSM state type and the access-width helper.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SB = 2'b01;
    localparam logic [1:0] ST_SH = 2'b10;

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_SPLIT  = 2'd2,
        S_RESP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd3
    } state_t;
`endif

    // Illegal size reports 4 bytes; such requests are faulted regardless.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extender: sign/zero-extends a low-aligned byte or half,
// passes words through. Shared by the direct and split-assembly load paths.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    always_comb begin
        data = '0;
        case (size)
            SZ_BYTE: data = {{24{~uns & raw[7]}}, raw[7:0]};
            SZ_HALF: data = {{16{~uns & raw[15]}}, raw[15:0]};
            SZ_WORD: data = raw;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and the byte-addressed data memory.
// Define MISALIGN_SPLIT_EN to split misaligned half/word accesses into byte steps.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    output logic [2:0]    dm_load,
    output logic [1:0]    dm_store,
    input  logic [31:0]   dm_rdata
);

    state_t        state, state_d, acc_state;
    logic          r_we, r_uns, r_err;
    logic [1:0]    r_size;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata, rdata_q;
    logic [31:0]   align_raw, align_out;
    logic          accept, req_misal, req_fault;
    logic [2:0]    req_nbytes;
    logic [AW:0]   req_last;
`ifdef MISALIGN_SPLIT_EN
    logic [1:0]    k;
    logic [2:0]    r_nbytes;
    logic [31:0]   asm_q, asm_next;
    logic          split_last, go_split;
`endif

    assign req_ready = (state == S_IDLE) || (state == S_RESP);
    assign accept    = req_valid && req_ready;

    // Last byte is computed one bit wider so a top-of-memory overrun shows as a carry.
    always_comb begin
        req_nbytes = size_bytes(req_size);
        req_last   = {1'b0, req_addr[AW-1:0]} + (AW+1)'(req_nbytes) - (AW+1)'(1);
        req_misal  = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        req_fault  = (req_size == SZ_ILL) || (req_addr[31:AW] != '0) || req_last[AW];
`ifdef MISALIGN_SPLIT_EN
        go_split   = req_misal && !req_fault;
        acc_state  = go_split ? S_SPLIT : S_ACCESS;
`else
        req_fault  = req_fault || req_misal;
        acc_state  = S_ACCESS;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (accept) state_d = acc_state;
            S_ACCESS: state_d = S_RESP;
`ifdef MISALIGN_SPLIT_EN
            S_SPLIT:  if (split_last) state_d = S_RESP;
`endif
            S_RESP:   state_d = accept ? acc_state : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

`ifdef MISALIGN_SPLIT_EN
    // Each split step merges the fetched byte into lane k; the final step's
    // merged word goes straight to the extender.
    always_comb begin
        r_nbytes   = size_bytes(r_size);
        split_last = ({1'b0, k} == (r_nbytes - 3'd1));
        asm_next   = asm_q;
        asm_next[{k, 3'b000} +: 8] = dm_rdata[7:0];
    end
    assign align_raw = (state == S_SPLIT) ? asm_next : dm_rdata;
`else
    assign align_raw = dm_rdata;
`endif

    mem_load_align u_align (
        .raw  (align_raw),
        .size (r_size),
        .uns  (r_uns),
        .data (align_out)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            rdata_q <= '0;
`ifdef MISALIGN_SPLIT_EN
            k       <= '0;
            asm_q   <= '0;
`endif
        end else begin
            if (accept) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_err   <= req_fault;
                r_size  <= req_size;
                r_addr  <= req_addr[AW-1:0];
                r_wdata <= req_wdata;
`ifdef MISALIGN_SPLIT_EN
                k       <= '0;
                asm_q   <= '0;
`endif
            end
            if (state == S_ACCESS)
                rdata_q <= (r_we || r_err) ? '0 : align_out;
`ifdef MISALIGN_SPLIT_EN
            if (state == S_SPLIT) begin
                asm_q <= asm_next;
                k     <= k + 2'd1;
                if (split_last)
                    rdata_q <= r_we ? '0 : align_out;
            end
`endif
        end
    end

    // Memory drive is decoded purely from registered request fields.
    always_comb begin
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_load  = LD_LW;
        dm_store = ST_SW;
        case (state)
            S_ACCESS: begin
                dm_addr = r_addr;
                if (r_we) begin
                    dm_we    = ~r_err;
                    dm_wdata = r_wdata;
                    case (r_size)
                        SZ_BYTE: dm_store = ST_SB;
                        SZ_HALF: dm_store = ST_SH;
                        default: dm_store = ST_SW;
                    endcase
                end else begin
                    case (r_size)
                        SZ_BYTE: dm_load = r_uns ? LD_LBU : LD_LB;
                        SZ_HALF: dm_load = r_uns ? LD_LHU : LD_LH;
                        default: dm_load = LD_LW;
                    endcase
                end
            end
`ifdef MISALIGN_SPLIT_EN
            S_SPLIT: begin
                dm_addr = r_addr + AW'(k);
                if (r_we) begin
                    dm_we    = 1'b1;
                    dm_store = ST_SB;
                    dm_wdata = {24'b0, r_wdata[{k, 3'b000} +: 8]};
                end else begin
                    dm_load  = LD_LBU;
                end
            end
`endif
            default: ;
        endcase
    end

    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule
